// File: rtl/simple_soc_axi_slave_mem.sv
// AXI slave backed by a word-addressed memory; independent read and write FSMs.
// Latency: first R beat the cycle after AR handshake; B the cycle after the last W handshake.
// Backpressure: R beat is held stable while rready=0; B is held until bready.
module simple_soc_axi_slave_mem #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64,
    parameter int ID_W   = 8,
    parameter int LEN_W  = 10,
    parameter int DEPTH  = 256
) (
    input  logic                aclk,
    input  logic                aresetn,
    // AW
    input  logic [ADDR_W-1:0]   awaddr,
    input  logic                awvalid,
    input  logic [LEN_W-1:0]    awlen,
    input  logic [1:0]          awburst,
    input  logic [2:0]          awsize,
    input  logic [1:0]          awlock,
    input  logic [2:0]          awprot,
    input  logic [3:0]          awcache,
    input  logic [ID_W-1:0]     awid,
    output logic                awready,
    // AR
    input  logic [ADDR_W-1:0]   araddr,
    input  logic                arvalid,
    input  logic [LEN_W-1:0]    arlen,
    input  logic [1:0]          arburst,
    input  logic [2:0]          arsize,
    input  logic [1:0]          arlock,
    input  logic [2:0]          arprot,
    input  logic [3:0]          arcache,
    input  logic [ID_W-1:0]     arid,
    output logic                arready,
    // W
    input  logic [DATA_W-1:0]   wdata,
    input  logic                wvalid,
    input  logic [DATA_W/8-1:0] wstrb,
    input  logic                wlast,
    input  logic [ID_W-1:0]     wid,
    output logic                wready,
    // R
    output logic [DATA_W-1:0]   rdata,
    output logic                rvalid,
    output logic                rlast,
    output logic [3:0]          rresp,
    output logic [ID_W-1:0]     rid,
    input  logic                rready,
    // B
    output logic [3:0]          bresp,
    output logic                bvalid,
    output logic [ID_W-1:0]     bid,
    input  logic                bready
);
    localparam int STRB_W = DATA_W / 8;
    localparam int SHIFT  = $clog2(STRB_W);
    localparam int IDX_W  = ADDR_W - SHIFT;
    localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [IDX_W-1:0] DEPTH_IDX = IDX_W'(DEPTH);
    localparam logic [3:0] RESP_OK     = 4'd0;
    localparam logic [3:0] RESP_SLVERR = 4'd2;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

    logic [DATA_W-1:0] mem [DEPTH];

    // Sideband fields carry no meaning for a flat memory.
    logic unused_inputs;
    assign unused_inputs = ^{awsize, awlock, awprot, awcache,
                             arsize, arlock, arprot, arcache, wid};

    // ---------------- write side ----------------
    w_state_t         w_state, w_state_nxt;
    logic [ID_W-1:0]  w_id;
    logic [IDX_W-1:0] w_idx;
    logic [LEN_W-1:0] w_len, w_cnt;
    logic             w_fixed, w_err;
    logic             aw_hs, w_hs, w_in_rng, w_beat_last;

    assign aw_hs       = awvalid && awready;
    assign w_hs        = wvalid && wready;
    assign w_in_rng    = (w_idx < DEPTH_IDX);
    assign w_beat_last = (w_cnt == w_len);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) w_state <= W_IDLE;
        else          w_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = w_state;
        awready     = 1'b0;
        wready      = 1'b0;
        bvalid      = 1'b0;
        case (w_state)
            W_IDLE: begin
                awready = 1'b1;
                if (awvalid) w_state_nxt = W_DATA;
            end
            W_DATA: begin
                wready = 1'b1;
                if (wvalid && w_beat_last) w_state_nxt = W_RESP;
            end
            W_RESP: begin
                bvalid = 1'b1;
                if (bready) w_state_nxt = W_IDLE;
            end
            default: w_state_nxt = W_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            w_id    <= '0;
            w_idx   <= '0;
            w_len   <= '0;
            w_cnt   <= '0;
            w_fixed <= 1'b0;
            w_err   <= 1'b0;
        end else if (aw_hs) begin
            w_id    <= awid;
            w_idx   <= awaddr[ADDR_W-1:SHIFT];
            w_len   <= awlen;
            w_cnt   <= '0;
            w_fixed <= (awburst == 2'b00);
            w_err   <= 1'b0;
        end else if (w_hs) begin
            if (!w_beat_last) w_cnt <= w_cnt + LEN_W'(1);
            if (!w_fixed)     w_idx <= w_idx + IDX_W'(1);
            // wlast must line up with the counted final beat on every beat
            if (!w_in_rng || (wlast != w_beat_last)) w_err <= 1'b1;
        end
    end

    assign bid   = w_id;
    assign bresp = (bvalid && w_err) ? RESP_SLVERR : RESP_OK;

    always_ff @(posedge aclk) begin
        if (w_hs && w_in_rng) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (wstrb[b]) mem[w_idx[MEM_AW-1:0]][b*8 +: 8] <= wdata[b*8 +: 8];
            end
        end
    end

    // ---------------- read side ----------------
    r_state_t          r_state, r_state_nxt;
    logic [ID_W-1:0]   r_id;
    logic [IDX_W-1:0]  r_idx;
    logic [LEN_W-1:0]  r_len, r_cnt;
    logic              r_fixed, ar_hs, r_hs, r_in_rng, r_beat_last;
    logic              r_hold_vld;
    logic [DATA_W-1:0] r_hold_dat, r_mem_dat;

    assign ar_hs       = arvalid && arready;
    assign r_hs        = rvalid && rready;
    assign r_in_rng    = (r_idx < DEPTH_IDX);
    assign r_beat_last = (r_cnt == r_len);
    assign r_mem_dat   = r_in_rng ? mem[r_idx[MEM_AW-1:0]] : '0;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) r_state <= R_IDLE;
        else          r_state <= r_state_nxt;
    end

    always_comb begin
        r_state_nxt = r_state;
        arready     = 1'b0;
        rvalid      = 1'b0;
        case (r_state)
            R_IDLE: begin
                arready = 1'b1;
                if (arvalid) r_state_nxt = R_DATA;
            end
            R_DATA: begin
                rvalid = 1'b1;
                if (rready && r_beat_last) r_state_nxt = R_IDLE;
            end
            default: r_state_nxt = R_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_id    <= '0;
            r_idx   <= '0;
            r_len   <= '0;
            r_cnt   <= '0;
            r_fixed <= 1'b0;
        end else if (ar_hs) begin
            r_id    <= arid;
            r_idx   <= araddr[ADDR_W-1:SHIFT];
            r_len   <= arlen;
            r_cnt   <= '0;
            r_fixed <= (arburst == 2'b00);
        end else if (r_hs && !r_beat_last) begin
            r_cnt <= r_cnt + LEN_W'(1);
            if (!r_fixed) r_idx <= r_idx + IDX_W'(1);
        end
    end

    // Freeze the presented word during a stall so a concurrent write cannot disturb it.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_hold_vld <= 1'b0;
            r_hold_dat <= '0;
        end else if (rvalid && !rready) begin
            r_hold_vld <= 1'b1;
            if (!r_hold_vld) r_hold_dat <= r_mem_dat;
        end else begin
            r_hold_vld <= 1'b0;
        end
    end

    assign rdata = rvalid ? (r_hold_vld ? r_hold_dat : r_mem_dat) : '0;
    assign rid   = r_id;
    assign rlast = rvalid && r_beat_last;
    assign rresp = (rvalid && !r_in_rng) ? RESP_SLVERR : RESP_OK;

endmodule

// File: tb/tb_simple_soc_axi_slave_mem.sv
// Randomized bench for simple_soc_axi_slave_mem against an array-based memory model.
module tb_simple_soc_axi_slave_mem;
    localparam int ADDR_W = 64, DATA_W = 64, ID_W = 8, LEN_W = 10, DEPTH = 256;

    logic              aclk = 1'b0;
    logic              aresetn;
    logic [ADDR_W-1:0] awaddr, araddr;
    logic              awvalid, arvalid, awready, arready;
    logic [LEN_W-1:0]  awlen, arlen;
    logic [1:0]        awburst, arburst, awlock, arlock;
    logic [2:0]        awsize, arsize, awprot, arprot;
    logic [3:0]        awcache, arcache;
    logic [ID_W-1:0]   awid, arid, wid, rid, bid;
    logic [DATA_W-1:0] wdata, rdata;
    logic              wvalid, wlast, wready;
    logic [7:0]        wstrb;
    logic              rvalid, rlast, rready, bvalid, bready;
    logic [3:0]        rresp, bresp;

    simple_soc_axi_slave_mem #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W),
                               .LEN_W(LEN_W), .DEPTH(DEPTH)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .awaddr(awaddr), .awvalid(awvalid), .awlen(awlen), .awburst(awburst),
        .awsize(awsize), .awlock(awlock), .awprot(awprot), .awcache(awcache),
        .awid(awid), .awready(awready),
        .araddr(araddr), .arvalid(arvalid), .arlen(arlen), .arburst(arburst),
        .arsize(arsize), .arlock(arlock), .arprot(arprot), .arcache(arcache),
        .arid(arid), .arready(arready),
        .wdata(wdata), .wvalid(wvalid), .wstrb(wstrb), .wlast(wlast), .wid(wid),
        .wready(wready),
        .rdata(rdata), .rvalid(rvalid), .rlast(rlast), .rresp(rresp), .rid(rid),
        .rready(rready),
        .bresp(bresp), .bvalid(bvalid), .bid(bid), .bready(bready)
    );

    always #5 aclk = ~aclk;

    int n_chk  = 0;
    int n_fail = 0;

    logic [63:0] mdl [0:DEPTH-1];
    logic [63:0] wd  [0:255];
    logic [7:0]  ws  [0:255];
    logic        wl  [0:255];

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic prep_beats(input int len);
        for (int i = 0; i <= len; i++) begin
            wd[i] = {$urandom, $urandom};
            ws[i] = 8'hFF;
            wl[i] = (i == len);
        end
    endtask

    task automatic do_write(input logic [63:0] addr, input int len, input logic [1:0] burst,
                            input logic [7:0] id);
        logic [63:0] idx;
        bit          err;
        int          cyc;
        err = 0;
        awaddr = addr; awlen = LEN_W'(len); awburst = burst; awid = id;
        awsize = 3'($urandom); awcache = 4'($urandom); awprot = 3'($urandom);
        awvalid = 1'b1;
        cyc = 0;
        while (!awready && cyc < 200) begin tick(); cyc++; end
        if (cyc >= 200) chk("aw_timeout", awready, 1);
        tick();
        awvalid = 1'b0;
        for (int i = 0; i <= len; i++) begin
            repeat ($urandom_range(0, 2)) tick();
            wdata = wd[i]; wstrb = ws[i]; wlast = wl[i]; wid = 8'($urandom);
            wvalid = 1'b1;
            cyc = 0;
            while (!wready && cyc < 200) begin tick(); cyc++; end
            if (cyc >= 200) chk("w_timeout", wready, 1);
            tick();
            wvalid = 1'b0;
            idx = (addr >> 3) + ((burst == 2'b00) ? 64'd0 : 64'(i));
            if (idx < DEPTH) begin
                for (int b = 0; b < 8; b++)
                    if (ws[i][b]) mdl[idx[7:0]][b*8 +: 8] = wd[i][b*8 +: 8];
            end else begin
                err = 1;
            end
            if (wl[i] != (i == len)) err = 1;
        end
        chk("b_valid", bvalid, 1);
        chk("b_id", bid, id);
        chk("b_resp", bresp, err ? 4'd2 : 4'd0);
        repeat ($urandom_range(0, 2)) begin
            tick();
            chk("b_hold", bvalid, 1);
        end
        bready = 1'b1;
        tick();
        bready = 1'b0;
        chk("b_done", bvalid, 0);
    endtask

    task automatic do_read(input logic [63:0] addr, input int len, input logic [1:0] burst,
                           input logic [7:0] id);
        logic [63:0] idx;
        int          beat, cyc;
        araddr = addr; arlen = LEN_W'(len); arburst = burst; arid = id;
        arsize = 3'($urandom); arcache = 4'($urandom); arlock = 2'($urandom);
        arvalid = 1'b1;
        cyc = 0;
        while (!arready && cyc < 200) begin tick(); cyc++; end
        if (cyc >= 200) chk("ar_timeout", arready, 1);
        tick();
        arvalid = 1'b0;
        beat = 0;
        cyc  = 0;
        while (beat <= len && cyc < 4000) begin
            idx = (addr >> 3) + ((burst == 2'b00) ? 64'd0 : 64'(beat));
            chk("r_valid", rvalid, 1);
            chk("r_data",  rdata, (idx < DEPTH) ? mdl[idx[7:0]] : 64'd0);
            chk("r_resp",  rresp, (idx < DEPTH) ? 4'd0 : 4'd2);
            chk("r_last",  rlast, (beat == len));
            chk("r_id",    rid, id);
            rready = 1'($urandom_range(0, 1));
            tick();
            if (rready) beat++;
            rready = 1'b0;
            cyc++;
        end
        if (cyc >= 4000) chk("r_timeout", rvalid, 0);
        chk("r_done", rvalid, 0);
    endtask

    initial begin
        awaddr = '0; awvalid = 0; awlen = '0; awburst = '0; awsize = '0; awlock = '0;
        awprot = '0; awcache = '0; awid = '0;
        araddr = '0; arvalid = 0; arlen = '0; arburst = '0; arsize = '0; arlock = '0;
        arprot = '0; arcache = '0; arid = '0;
        wdata = '0; wvalid = 0; wstrb = '0; wlast = 0; wid = '0;
        rready = 0; bready = 0;
        aresetn = 1'b1;
        #2 aresetn = 1'b0;
        repeat (3) tick();
        chk("rst_awready", awready, 1);
        chk("rst_arready", arready, 1);
        chk("rst_wready",  wready, 0);
        chk("rst_rvalid",  rvalid, 0);
        chk("rst_rlast",   rlast, 0);
        chk("rst_bvalid",  bvalid, 0);
        chk("rst_rresp",   rresp, 0);
        chk("rst_bresp",   bresp, 0);
        chk("rst_rid",     rid, 0);
        chk("rst_bid",     bid, 0);
        chk("rst_rdata",   rdata, 0);
        aresetn = 1'b1;
        tick();

        // fill whole memory so every later read has a defined model value
        prep_beats(DEPTH - 1);
        do_write(64'h0, DEPTH - 1, 2'b01, 8'h11);

        // single beat write then read back
        prep_beats(0);
        wd[0] = 64'hA5A5;
        do_write(64'h10, 0, 2'b01, 8'h05);
        do_read(64'h10, 0, 2'b01, 8'h06);

        // INCR burst 1,2,3,4 read back with random rready stalls
        prep_beats(3);
        for (int i = 0; i < 4; i++) wd[i] = 64'(i + 1);
        do_write(64'h0, 3, 2'b01, 8'h21);
        do_read(64'h0, 3, 2'b01, 8'h22);

        // byte strobes
        prep_beats(0);
        wd[0] = '1;
        do_write(64'h40, 0, 2'b01, 8'h31);
        wd[0] = '0; ws[0] = 8'h0F;
        do_write(64'h40, 0, 2'b01, 8'h32);
        do_read(64'h40, 0, 2'b01, 8'h33);

        // out of range write, then read straddling the top of memory
        prep_beats(0);
        do_write(64'(DEPTH) * 8, 0, 2'b01, 8'h41);
        do_read(64'h0, 0, 2'b01, 8'h42);
        do_read(64'(DEPTH - 1) * 8, 1, 2'b01, 8'h43);

        // wlast asserted early
        prep_beats(1);
        wl[0] = 1'b1; wl[1] = 1'b0;
        do_write(64'h100, 1, 2'b01, 8'h51);
        do_read(64'h100, 1, 2'b01, 8'h52);

        // FIXED burst stays on one word
        prep_beats(3);
        do_write(64'h80, 3, 2'b00, 8'h61);
        do_read(64'h80, 2, 2'b00, 8'h62);

        // random transactions, including unaligned addresses and range overflow
        for (int t = 0; t < 25; t++) begin
            logic [63:0] a;
            int          l;
            logic [1:0]  bu;
            a  = 64'($urandom_range(0, DEPTH + 3)) * 8 + 64'($urandom_range(0, 7));
            l  = $urandom_range(0, 7);
            bu = 2'($urandom);
            prep_beats(l);
            for (int i = 0; i <= l; i++) ws[i] = 8'($urandom);
            do_write(a, l, bu, 8'($urandom));
            do_read(a, l, 2'($urandom_range(1, 3)), 8'($urandom));
        end

        // overlapping read and write on disjoint regions
        prep_beats(7);
        fork
            do_write(64'd128 * 8, 7, 2'b01, 8'h71);
            do_read(64'h0, 7, 2'b01, 8'h72);
        join
        do_read(64'd128 * 8, 7, 2'b01, 8'h73);

        // reset in the middle of a write burst: first beat lands, no response
        awaddr = 64'd64 * 8; awlen = 10'd3; awburst = 2'b01; awid = 8'h81; awvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        wdata = 64'hDEAD_BEEF_0000_0001; wstrb = 8'hFF; wlast = 1'b0; wvalid = 1'b1;
        chk("mw_wready", wready, 1);
        tick();
        wvalid = 1'b0;
        mdl[64] = 64'hDEAD_BEEF_0000_0001;
        aresetn = 1'b0;
        #1;
        chk("mw_wready_rst", wready, 0);
        chk("mw_awready_rst", awready, 1);
        tick();
        aresetn = 1'b1;
        repeat (3) begin
            tick();
            chk("mw_no_bvalid", bvalid, 0);
        end
        do_read(64'd64 * 8, 1, 2'b01, 8'h82);

        // reset in the middle of a read burst
        araddr = 64'h0; arlen = 10'd7; arburst = 2'b01; arid = 8'h91; arvalid = 1'b1;
        tick();
        arvalid = 1'b0;
        rready = 1'b1;
        repeat (2) tick();
        chk("mr_rvalid", rvalid, 1);
        chk("mr_rdata", rdata, mdl[2]);
        aresetn = 1'b0;
        #1;
        chk("mr_rvalid_rst", rvalid, 0);
        chk("mr_arready_rst", arready, 1);
        chk("mr_rdata_rst", rdata, 0);
        rready = 1'b0;
        tick();
        aresetn = 1'b1;
        tick();
        do_read(64'h0, 7, 2'b01, 8'h92);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
